// File: rtl/sv_mm_pkg.sv
// Shared types for the modular-multiply sequencer: arithmetic-unit op codes,
// FSM states and the state-to-op mapping.
package sv_mm_pkg;

    typedef enum logic [2:0] {
        LA_DEC  = 3'd0,
        LA_INC  = 3'd1,
        LA_SHR  = 3'd2,
        LA_ADDM = 3'd3,
        LA_SUBM = 3'd4,
        LA_PASS = 3'd5,
        LA_EQ   = 3'd6,
        LA_ODD  = 3'd7
    } la_op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHK_Z   = 3'd1,
        CHK_ODD = 3'd2,
        ADD     = 3'd3,
        DBL     = 3'd4,
        SHR     = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Op code the arithmetic unit must execute while the FSM sits in state s.
    function automatic la_op_t op_of(input state_t s);
        case (s)
            CHK_Z:   return LA_EQ;
            CHK_ODD: return LA_ODD;
            ADD:     return LA_ADDM;
            DBL:     return LA_ADDM;
            SHR:     return LA_SHR;
            default: return LA_PASS;
        endcase
    endfunction

endpackage

// File: rtl/sv_mm_seq.sv
// Sequencer for r = (k * x) mod q by LSB-first double-and-add on an external ALU.
// Optional macro SV_MM_CONST_TIME_EN: fixed BLOCK_SIZE iterations, always-executed add.
module sv_mm_seq
    import sv_mm_pkg::*;
#(
    parameter int BLOCK_SIZE = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] q_i     [BLOCK_SIZE/8],
    input  logic [7:0] x_i     [BLOCK_SIZE/8],
    input  logic [7:0] k_i     [BLOCK_SIZE/8],
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] r_o     [BLOCK_SIZE/8],
    output logic [2:0] alu_op_o,
    output logic [7:0] alu_q_o [BLOCK_SIZE/8],
    output logic [7:0] alu_a_o [BLOCK_SIZE/8],
    output logic [7:0] alu_b_o [BLOCK_SIZE/8],
    input  logic [7:0] alu_r_i [BLOCK_SIZE/8],
    input  logic       alu_c_i
);

    localparam int NB = BLOCK_SIZE / 8;

    logic [BLOCK_SIZE-1:0] q_in, x_in, k_in, alu_r;
    logic [BLOCK_SIZE-1:0] q_r, x_r, k_r, acc_r, res_r;
    logic [BLOCK_SIZE-1:0] a_drv, b_drv;

    state_t state, state_nxt;
    la_op_t op_r;

`ifdef SV_MM_CONST_TIME_EN
    localparam int CW = $clog2(BLOCK_SIZE + 1);
    logic [CW-1:0]         cnt_r;
    logic                  odd_r;
    logic [BLOCK_SIZE-1:0] dummy_r;
`endif

    for (genvar i = 0; i < NB; i++) begin : g_bytes
        assign q_in[8*i +: 8] = q_i[i];
        assign x_in[8*i +: 8] = x_i[i];
        assign k_in[8*i +: 8] = k_i[i];
        assign alu_r[8*i +: 8] = alu_r_i[i];
        assign r_o[i]     = res_r[8*i +: 8];
        assign alu_q_o[i] = q_r[8*i +: 8];
        assign alu_a_o[i] = a_drv[8*i +: 8];
        assign alu_b_o[i] = b_drv[8*i +: 8];
    end

    assign busy_o   = (state != IDLE);
    assign done_o   = (state == DONE);
    assign alu_op_o = op_r;

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = CHK_Z;
`ifdef SV_MM_CONST_TIME_EN
            CHK_Z:   state_nxt = (cnt_r == CW'(BLOCK_SIZE)) ? DONE : CHK_ODD;
            CHK_ODD: state_nxt = ADD;
`else
            CHK_Z:   state_nxt = alu_c_i ? DONE : CHK_ODD;
            CHK_ODD: state_nxt = alu_c_i ? ADD : DBL;
`endif
            ADD:     state_nxt = DBL;
            DBL:     state_nxt = SHR;
            SHR:     state_nxt = CHK_Z;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_drv = '0;
        b_drv = '0;
        case (state)
            CHK_Z:   a_drv = k_r;
            CHK_ODD: b_drv = k_r;
            ADD:     begin a_drv = acc_r; b_drv = x_r; end
            DBL:     begin a_drv = x_r;   b_drv = x_r; end
            SHR:     b_drv = k_r;
            default: ;
        endcase
    end

    // The op code is registered from the next state so it reads 0 under reset
    // yet still matches the state it accompanies once running.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state uses non-blocking assignments throughout.
            state <= IDLE;
            op_r  <= LA_DEC;
            q_r   <= '0;
            x_r   <= '0;
            k_r   <= '0;
            acc_r <= '0;
            res_r <= '0;
`ifdef SV_MM_CONST_TIME_EN
            cnt_r   <= '0;
            odd_r   <= 1'b0;
            dummy_r <= '0;
`endif
        end else begin
            state <= state_nxt;
            op_r  <= op_of(state_nxt);
            case (state)
                IDLE: if (start_i) begin
                    q_r   <= q_in;
                    x_r   <= x_in;
                    k_r   <= k_in;
                    acc_r <= '0;
`ifdef SV_MM_CONST_TIME_EN
                    cnt_r <= '0;
                    odd_r <= 1'b0;
`endif
                end
`ifdef SV_MM_CONST_TIME_EN
                CHK_ODD: odd_r <= alu_c_i;
                ADD: begin
                    if (odd_r) acc_r   <= alu_r;
                    else       dummy_r <= alu_r;
                end
                SHR: begin
                    k_r   <= alu_r;
                    cnt_r <= cnt_r + 1'b1;
                end
`else
                ADD: acc_r <= alu_r;
                SHR: k_r   <= alu_r;
`endif
                DBL: x_r <= alu_r;
                default: ;
            endcase
            // acc is final once CHK_Z decides to finish, so r_o is valid with done_o.
            if (state_nxt == DONE) res_r <= acc_r;
        end
    end

endmodule

// File: tb/tb_sv_mm_seq.sv
// Self-checking bench for sv_mm_seq (BLOCK_SIZE=16) with a behavioural ALU and
// a (k*x) mod q reference model; honours SV_MM_CONST_TIME_EN for latency.
module tb_sv_mm_seq;

    localparam int BS = 16;
    localparam int NB = BS / 8;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic [7:0] q_i [NB];
    logic [7:0] x_i [NB];
    logic [7:0] k_i [NB];
    logic       busy_o, done_o;
    logic [7:0] r_o [NB];
    logic [2:0] alu_op_o;
    logic [7:0] alu_q_o [NB];
    logic [7:0] alu_a_o [NB];
    logic [7:0] alu_b_o [NB];
    logic [7:0] alu_r_i [NB];
    logic       alu_c_i;

    int checks = 0;
    int failures = 0;

    sv_mm_seq #(.BLOCK_SIZE(BS)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .q_i(q_i), .x_i(x_i), .k_i(k_i),
        .busy_o(busy_o), .done_o(done_o), .r_o(r_o),
        .alu_op_o(alu_op_o), .alu_q_o(alu_q_o), .alu_a_o(alu_a_o),
        .alu_b_o(alu_b_o), .alu_r_i(alu_r_i), .alu_c_i(alu_c_i)
    );

    always #5 clk = ~clk;

    // Behavioural arithmetic unit: the environment the sequencer drives.
    logic [BS-1:0] m_a, m_b, m_q, m_r;
    logic [BS:0]   m_s;
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            m_a[8*i +: 8] = alu_a_o[i];
            m_b[8*i +: 8] = alu_b_o[i];
            m_q[8*i +: 8] = alu_q_o[i];
        end
        m_r = '0;
        m_s = '0;
        alu_c_i = 1'b0;
        case (alu_op_o)
            3'd0: m_r = m_b - 1'b1;
            3'd1: m_r = m_b + 1'b1;
            3'd2: m_r = m_b >> 1;
            3'd3: begin
                m_s = {1'b0, m_a} + {1'b0, m_b};
                if (m_s >= {1'b0, m_q}) m_s = m_s - {1'b0, m_q};
                m_r = m_s[BS-1:0];
            end
            3'd4: m_r = (m_a >= m_b) ? (m_a - m_b) : (m_a + m_q - m_b);
            3'd5: m_r = m_b;
            3'd6: alu_c_i = (m_a == m_b);
            default: alu_c_i = m_b[0];
        endcase
        for (int i = 0; i < NB; i++) alu_r_i[i] = m_r[8*i +: 8];
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint r_val();
        longint v = 0;
        for (int i = 0; i < NB; i++) v |= longint'(r_o[i]) << (8 * i);
        return v;
    endfunction

    function automatic longint bus_val(input logic [7:0] b [NB]);
        longint v = 0;
        for (int i = 0; i < NB; i++) v |= longint'(b[i]) << (8 * i);
        return v;
    endfunction

    // Reference latency from the bit pattern of k.
    function automatic int latency(input int unsigned k);
`ifdef SV_MM_CONST_TIME_EN
        return 2 + 5 * BS;
`else
        int len = 0;
        int pop = 0;
        for (int i = 0; i < BS; i++) begin
            if (k[i]) begin
                len = i + 1;
                pop++;
            end
        end
        return 2 + 4 * len + pop;
`endif
    endfunction

    task automatic set_inputs(input int unsigned q, input int unsigned x, input int unsigned k);
        for (int i = 0; i < NB; i++) begin
            q_i[i] = q[8*i +: 8];
            x_i[i] = x[8*i +: 8];
            k_i[i] = k[8*i +: 8];
        end
    endtask

    task automatic run_op(input string tag, input int unsigned q, input int unsigned x,
                          input int unsigned k);
        longint exp_r;
        int n;
        exp_r = (longint'(k) * longint'(x)) % longint'(q);
        set_inputs(q, x, k);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        n = 1;
        check({tag, "_busy"}, busy_o, 1);
        while (!done_o && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, latency(k));
        check({tag, "_busy_done"}, busy_o, 1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done_o, 0);
        check({tag, "_idle"}, busy_o, 0);
        check({tag, "_r"}, r_val(), exp_r);
    endtask

    initial begin
        int n;
        int unsigned q, x, k;
        rst_ni  = 1'b0;
        start_i = 1'b0;
        set_inputs(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_r", r_val(), 0);
        check("rst_op", alu_op_o, 0);
        check("rst_a", bus_val(alu_a_o), 0);
        check("rst_b", bus_val(alu_b_o), 0);
        check("rst_q", bus_val(alu_q_o), 0);
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check("idle_op_pass", alu_op_o, 5);

        run_op("d_97_5_3", 97, 5, 3);
        run_op("d_k0", 97, 40, 0);
        run_op("d_wrap", 97, 96, 2);
        run_op("d_kffff", 97, 5, 16'hFFFF);

        // Abort in ADD: cycle 3 after the start edge for k=3.
        run_op("pre_abort", 97, 5, 3);
        set_inputs(97, 5, 3);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("abort_in_add", alu_op_o, 3);
        rst_ni = 1'b0;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_r", r_val(), 0);
        check("abort_op", alu_op_o, 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_done", done_o, 0);
        end
        rst_ni = 1'b1;
        @(posedge clk); #1;
        run_op("post_abort", 97, 5, 3);

        // start held high and inputs changed while busy: only the first is used.
        set_inputs(97, 5, 3);
        start_i = 1'b1;
        @(posedge clk); #1;
        set_inputs(97, 7, 5);
        n = 1;
        while (!done_o && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        start_i = 1'b0;
        check("held_lat", n, latency(3));
        @(posedge clk); #1;
        check("held_idle", busy_o, 0);
        check("held_r", r_val(), 15);
        repeat (2) begin @(posedge clk); #1; end
        check("held_no_restart", busy_o, 0);
        run_op("held_second", 97, 7, 5);

        for (int i = 0; i < 20; i++) begin
            q = $urandom_range(65535, 2);
            x = $urandom % q;
            k = (i % 3 == 0) ? $urandom_range(15, 0) : ($urandom & 32'hFFFF);
            run_op($sformatf("rnd%0d", i), q, x, k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
